// File: rtl/gate_unit_pkg.sv
// Shared op-code definitions for the gate_unit bitwise reduction pipeline.
package gate_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_BUF  = 3'd7
  } gate_op_e;

endpackage

// File: rtl/gate_unit_reduce.sv
// Combinational bitwise reduction over the unmasked operands (module gate_reduce).
module gate_reduce
  import gate_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NIN   = 4
) (
  input  logic [NIN*WIDTH-1:0] data,
  input  logic [NIN-1:0]       mask,
  input  gate_op_e             op,
  output logic [WIDTH-1:0]     result
);

  logic [WIDTH-1:0] acc_and;
  logic [WIDTH-1:0] acc_or;
  logic [WIDTH-1:0] acc_xor;

  // Masked operands fall out as the identity of each reduction.
  always_comb begin
    acc_and = '1;
    acc_or  = '0;
    acc_xor = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (mask[k]) begin
        acc_and = acc_and & data[k*WIDTH +: WIDTH];
        acc_or  = acc_or  | data[k*WIDTH +: WIDTH];
        acc_xor = acc_xor ^ data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = acc_and;
      OP_OR:   result = acc_or;
      OP_XOR:  result = acc_xor;
      OP_NAND: result = ~acc_and;
      OP_NOR:  result = ~acc_or;
      OP_XNOR: result = ~acc_xor;
      OP_NOT:  result = ~data[WIDTH-1:0];
      OP_BUF:  result = data[WIDTH-1:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit.sv
// Two-stage valid/ready bitwise gate pipeline: S1 holds operands, S2 holds result.
// Optional out_parity port enabled by defining GATE_UNIT_PARITY_EN.
module gate_unit
  import gate_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NIN   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NIN*WIDTH-1:0] in_data,
  input  logic [NIN-1:0]       in_mask,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [2:0]           out_op
`ifdef GATE_UNIT_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  logic                 s1_valid_q, s1_valid_d;
  logic [NIN*WIDTH-1:0] s1_data_q, s1_data_d;
  logic [NIN-1:0]       s1_mask_q, s1_mask_d;
  gate_op_e             s1_op_q, s1_op_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_data_q, s2_data_d;
  gate_op_e             s2_op_q, s2_op_d;
  logic                 s2_free;
  logic                 s2_load;
  logic                 in_fire;
  logic [WIDTH-1:0]     reduce_result;

  gate_reduce #(
    .WIDTH(WIDTH),
    .NIN  (NIN)
  ) u_reduce (
    .data  (s1_data_q),
    .mask  (s1_mask_q),
    .op    (s1_op_q),
    .result(reduce_result)
  );

  // in_ready is gated by rst_n so it reads 0 throughout reset.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s2_load  = s1_valid_q && s2_free;
    in_ready = rst_n && (!s1_valid_q || s2_free);
    in_fire  = in_valid && in_ready;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_mask_d  = s1_mask_q;
    s1_op_d    = s1_op_q;
    if (!s1_valid_q || s2_free) begin
      s1_valid_d = in_fire;
    end
    if (in_fire) begin
      s1_data_d = in_data;
      s1_mask_d = in_mask;
      s1_op_d   = gate_op_e'(in_op);
    end

    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    s2_data_d  = s2_load ? reduce_result : s2_data_q;
    s2_op_d    = s2_load ? s1_op_q : s2_op_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mask_q  <= '0;
      s1_op_q    <= OP_AND;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_op_q    <= OP_AND;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_mask_q  <= s1_mask_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_op_q    <= s2_op_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_op    = s2_op_q;

`ifdef GATE_UNIT_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = s2_load ? ^reduce_result : parity_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_gate_unit.sv
// Directed self-checking bench for gate_unit (WIDTH=8, NIN=4).
module tb_gate_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_mask;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_op;
`ifdef GATE_UNIT_PARITY_EN
  logic        out_parity;
`endif

  int checks = 0;
  int errors = 0;

  gate_unit #(
    .WIDTH(8),
    .NIN  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mask  (in_mask),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_op   (out_op)
`ifdef GATE_UNIT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  mask;
    logic [2:0]  op;
    logic [7:0]  exp;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One isolated transfer; result must appear on the second edge after acceptance.
  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    @(negedge clk);
    in_valid = 1'b1; in_data = v.data; in_mask = v.mask; in_op = v.op;
    #1;
    check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({nm, " early_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({nm, " out_valid"}, 64'(out_valid), 64'd1);
    check({nm, " out_data"}, 64'(out_data), 64'(v.exp));
    check({nm, " out_op"}, 64'(out_op), 64'(v.op));
`ifdef GATE_UNIT_PARITY_EN
    check({nm, " out_parity"}, 64'(out_parity), 64'(^v.exp));
`endif
  endtask

  localparam logic [31:0] OPS = 32'hF0FF3C0F;

  initial begin
    vec_t vecs[18];
    bit   pat[4];
    int   sent, rcv, cyc;
    bit   was_stalled, saw_block;
    logic [7:0] held;

    vecs[0]  = '{OPS, 4'b1111, 3'd0, 8'h00};
    vecs[1]  = '{OPS, 4'b0011, 3'd2, 8'h33};
    vecs[2]  = '{OPS, 4'b0011, 3'd4, 8'hC0};
    vecs[3]  = '{OPS, 4'b0011, 3'd6, 8'hF0};
    vecs[4]  = '{OPS, 4'b0000, 3'd0, 8'hFF};
    vecs[5]  = '{OPS, 4'b0000, 3'd1, 8'h00};
    vecs[6]  = '{OPS, 4'b0000, 3'd4, 8'hFF};
    vecs[7]  = '{OPS, 4'b0000, 3'd2, 8'h00};
    vecs[8]  = '{OPS, 4'b0000, 3'd3, 8'h00};
    vecs[9]  = '{OPS, 4'b0000, 3'd5, 8'hFF};
    vecs[10] = '{OPS, 4'b1111, 3'd1, 8'hFF};
    vecs[11] = '{OPS, 4'b0011, 3'd3, 8'hF3};
    vecs[12] = '{OPS, 4'b1111, 3'd5, 8'hC3};
    vecs[13] = '{OPS, 4'b0000, 3'd7, 8'h0F};
    vecs[14] = '{OPS, 4'b1010, 3'd2, 8'hCC};
    vecs[15] = '{OPS, 4'b0110, 3'd0, 8'h3C};
    vecs[16] = '{32'hF0FF3C31, 4'b0000, 3'd7, 8'h31};
    vecs[17] = '{OPS, 4'b0000, 3'd6, 8'hF0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mask = '0; in_op = '0; out_ready = 1'b1;
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_data", 64'(out_data), 64'd0);
    check("rst out_op", 64'(out_op), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-rst in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Streaming under a 1,0,0,1 out_ready pattern; BUF returns operand 0 = A0+n.
    sent = 0; rcv = 0; cyc = 0; was_stalled = 0; saw_block = 0; held = '0;
    while (rcv < 10 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 10);
      in_data   = {24'hF0FF3C, 8'(8'hA0 + sent)};
      in_mask   = 4'b1111;
      in_op     = 3'd7;
      #1;
      if (was_stalled) begin
        check("stall hold valid", 64'(out_valid), 64'd1);
        check("stall hold data", 64'(out_data), 64'(held));
      end
      check("bp in_ready", 64'(in_ready), 64'(!((sent - rcv) == 2 && !out_ready)));
      if (!in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        check("bp order", 64'(out_data), 64'(8'(8'hA0 + rcv)));
        rcv++;
      end
      was_stalled = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("bp all received", 64'(rcv), 64'd10);
    check("bp in_ready dropped", 64'(saw_block), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("bp no extra", 64'(out_valid), 64'd0);

    // Reset with two results in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = {24'hF0FF3C, 8'h55}; in_op = 3'd7;
    @(negedge clk);
    in_data = {24'hF0FF3C, 8'h66};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre-rst out_valid", 64'(out_valid), 64'd1);
    check("pre-rst out_data", 64'(out_data), 64'h55);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 64'(out_valid), 64'd0);
    check("mid-rst out_data", 64'(out_data), 64'd0);
    check("mid-rst in_ready", 64'(in_ready), 64'd0);
`ifdef GATE_UNIT_PARITY_EN
    check("mid-rst out_parity", 64'(out_parity), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("rel in_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("no stale c%0d", c), 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
